sna_response: RTL and testbench



---
 rtl/sna_response.sv | 94 +++++++++
 tb/tb_sna_response.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sna_response.sv
// SNA response transmitter: turns an AXI-Lite read/write response
// into a header+tail packet on the NoC and acks the AXI side.
module sna_response #(
  parameter int FLIT_W = 37,
  parameter int NUM_VC = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [FLIT_W-1:0] header,
  input  logic [FLIT_W-1:0] tail,
  input  logic              rvalid,
  input  logic              bvalid,
  input  logic [NUM_VC-1:0] is_allocatable,
  input  logic [NUM_VC-1:0] is_on_off,
  output logic [FLIT_W-1:0] noc_data,
  output logic              is_valid,
  output logic              rready,
  output logic              bready
);

  localparam int VC_W  = $clog2(NUM_VC);
  localparam int VC_HI = FLIT_W - 3;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_VC   = 2'd1;
  localparam logic [1:0] SEND_TAIL = 2'd2;
  localparam logic [1:0] ACK       = 2'd3;

  logic [1:0]      state;
  logic            kind_wr;
  logic [VC_W-1:0] vc;

  logic acking;
  logic vc_alloc;
  logic vc_on;

  // A pulse in flight means AXI has not yet dropped valid.
  assign acking   = rready | bready;
  assign vc_alloc = is_allocatable[vc];
  assign vc_on    = is_on_off[vc];

  // Packet sequencer with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      kind_wr  <= 1'b0;
      vc       <= '0;
      noc_data <= '0;
      is_valid <= 1'b0;
      rready   <= 1'b0;
      bready   <= 1'b0;
    end else begin
      is_valid <= 1'b0;
      rready   <= 1'b0;
      bready   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!acking) begin
            if (rvalid) begin
              kind_wr <= 1'b0;
              vc      <= header[VC_HI -: VC_W];
              state   <= WAIT_VC;
            end else if (bvalid) begin
              kind_wr <= 1'b1;
              vc      <= header[VC_HI -: VC_W];
              state   <= WAIT_VC;
            end
          end
        end
        WAIT_VC: begin
          if (vc_alloc && vc_on) begin
            noc_data <= header;
            is_valid <= 1'b1;
            state    <= SEND_TAIL;
          end
        end
        SEND_TAIL: begin
          if (vc_on) begin
            noc_data <= tail;
            is_valid <= 1'b1;
            state    <= ACK;
          end
        end
        ACK: begin
          rready <= ~kind_wr;
          bready <= kind_wr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sna_response.sv
// Directed and randomized bench for sna_response against a
// packet-level reference model.
module tb_sna_response;

  logic        clock = 1'b0;
  logic        reset;
  logic [36:0] header;
  logic [36:0] tail;
  logic        rvalid;
  logic        bvalid;
  logic [7:0]  is_allocatable;
  logic [7:0]  is_on_off;
  logic [36:0] noc_data;
  logic        is_valid;
  logic        rready;
  logic        bready;

  int checks = 0;
  int fails  = 0;

  // Reference model: one pending packet, flits sent so far.
  bit          m_busy;
  bit          m_wr;
  bit [2:0]    m_vc;
  int          m_sent;
  bit          m_valid;
  bit          m_r;
  bit          m_b;
  bit          m_known;
  logic [36:0] m_data;

  always #5 clock = ~clock;

  sna_response dut (
    .clock          (clock),
    .reset          (reset),
    .header         (header),
    .tail           (tail),
    .rvalid         (rvalid),
    .bvalid         (bvalid),
    .is_allocatable (is_allocatable),
    .is_on_off      (is_on_off),
    .noc_data       (noc_data),
    .is_valid       (is_valid),
    .rready         (rready),
    .bready         (bready)
  );

  task automatic chk(string tag, logic [36:0] obs, logic [36:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit nv;
    bit nr;
    bit nb;
    nv = 0;
    nr = 0;
    nb = 0;
    if (reset) begin
      m_busy  = 0;
      m_sent  = 0;
      m_data  = '0;
      m_valid = 0;
      m_r     = 0;
      m_b     = 0;
      m_known = 1;
      return;
    end
    if (!m_busy) begin
      if (!m_r && !m_b && (rvalid || bvalid)) begin
        m_busy = 1;
        m_wr   = !rvalid;
        m_vc   = header[34:32];
        m_sent = 0;
      end
    end else if (m_sent == 0) begin
      if (is_allocatable[m_vc] && is_on_off[m_vc]) begin
        m_data = header;
        nv     = 1;
        m_sent = 1;
      end
    end else if (m_sent == 1) begin
      if (is_on_off[m_vc]) begin
        m_data = tail;
        nv     = 1;
        m_sent = 2;
      end
    end else begin
      nr     = !m_wr;
      nb     = m_wr;
      m_busy = 0;
    end
    m_known = nv || (m_busy && m_sent == 1);
    m_valid = nv;
    m_r     = nr;
    m_b     = nb;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk("is_valid", {36'd0, is_valid}, {36'd0, m_valid});
    chk("rready", {36'd0, rready}, {36'd0, m_r});
    chk("bready", {36'd0, bready}, {36'd0, m_b});
    if (m_known) chk("noc_data", noc_data, m_data);
    chk("rb_excl", {36'd0, rready & bready}, 37'd0);
    if (rready) rvalid = 1'b0;
    if (bready) bvalid = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    header         = '0;
    tail           = '0;
    rvalid         = 1'b0;
    bvalid         = 1'b0;
    is_allocatable = '0;
    is_on_off      = '0;
    m_busy = 0; m_wr = 0; m_vc = 0; m_sent = 0;
    m_valid = 0; m_r = 0; m_b = 0; m_known = 0; m_data = '0;

    step();
    step();
    chk("rst_data", noc_data, 37'd0);
    chk("rst_valid", {36'd0, is_valid}, 37'd0);
    reset = 1'b0;

    // read response, VC 1 ready
    header         = 37'h113100000;
    tail           = 37'h090000000;
    is_allocatable = 8'h02;
    is_on_off      = 8'h02;
    rvalid         = 1'b1;
    step();
    chk("t1_wait", {36'd0, is_valid}, 37'd0);
    step();
    chk("t1_hdr_v", {36'd0, is_valid}, 37'd1);
    chk("t1_hdr", noc_data, 37'h113100000);
    step();
    chk("t1_tail_v", {36'd0, is_valid}, 37'd1);
    chk("t1_tail", noc_data, 37'h090000000);
    step();
    chk("t1_rready", {36'd0, rready}, 37'd1);
    chk("t1_bready", {36'd0, bready}, 37'd0);
    step();
    chk("t1_rdone", {36'd0, rready}, 37'd0);

    // allocation stall
    is_allocatable = 8'h00;
    rvalid         = 1'b1;
    step();
    repeat (3) begin
      step();
      chk("t2_stall", {36'd0, is_valid}, 37'd0);
    end
    is_allocatable = 8'h02;
    step();
    chk("t2_hdr", noc_data, 37'h113100000);
    step();
    step();
    chk("t2_rready", {36'd0, rready}, 37'd1);
    step();

    // on/off stall between header and tail
    rvalid = 1'b1;
    step();
    step();
    is_on_off = 8'h00;
    repeat (2) begin
      step();
      chk("t3_stall_v", {36'd0, is_valid}, 37'd0);
      chk("t3_hold", noc_data, 37'h113100000);
    end
    is_on_off = 8'h02;
    step();
    chk("t3_tail", noc_data, 37'h090000000);
    step();
    chk("t3_rready", {36'd0, rready}, 37'd1);
    step();

    // write response, then read/write priority
    bvalid = 1'b1;
    step();
    step();
    step();
    step();
    chk("t4_bready", {36'd0, bready}, 37'd1);
    chk("t4_rready", {36'd0, rready}, 37'd0);
    step();
    rvalid = 1'b1;
    bvalid = 1'b1;
    step();
    step();
    step();
    step();
    chk("t4_rfirst", {36'd0, rready}, 37'd1);
    chk("t4_bwait", {36'd0, bready}, 37'd0);
    step();
    step();
    step();
    step();
    step();
    chk("t4_bsecond", {36'd0, bready}, 37'd1);
    step();

    // reset while waiting to send the tail
    rvalid = 1'b1;
    step();
    step();
    is_on_off = 8'h00;
    step();
    reset  = 1'b1;
    rvalid = 1'b0;
    step();
    chk("t5_data", noc_data, 37'd0);
    chk("t5_valid", {36'd0, is_valid}, 37'd0);
    reset     = 1'b0;
    is_on_off = 8'h02;
    repeat (4) begin
      step();
      chk("t5_nopulse", {36'd0, rready}, 37'd0);
      chk("t5_noflit", {36'd0, is_valid}, 37'd0);
    end

    // header targets VC 3, only VC 0 allocatable
    header         = 37'h13DEADBEEF;
    tail           = 37'h08CAFEF00D;
    is_allocatable = 8'h01;
    is_on_off      = 8'hFF;
    bvalid         = 1'b1;
    step();
    repeat (4) begin
      step();
      chk("t6_blocked", {36'd0, is_valid}, 37'd0);
    end
    is_allocatable = 8'h08;
    step();
    chk("t6_hdr", noc_data, 37'h13DEADBEEF);
    step();
    chk("t6_tail", noc_data, 37'h08CAFEF00D);
    step();
    chk("t6_bready", {36'd0, bready}, 37'd1);
    step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!rvalid && !bvalid && !m_busy) begin
        header = {2'b10, 3'($urandom), 32'($urandom)};
        tail   = {2'b01, 3'($urandom), 32'($urandom)};
      end
      if (!rvalid && $urandom_range(0, 3) == 0) rvalid = 1'b1;
      if (!bvalid && $urandom_range(0, 3) == 0) bvalid = 1'b1;
      is_allocatable = 8'($urandom);
      is_on_off      = 8'($urandom | $urandom);
      step();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
